// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline-side request/response bundle for sram_controller
interface sram_controller_if #(
    parameter int N = 32
);
    logic [N-1:0] ALU_ResIn;
    logic [N-1:0] Value_RmIn;
    logic         MEM_W_ENIn;
    logic         MEM_R_ENIn;
    logic [N-1:0] readData;
    logic         ready;

    // memory stage side: issues requests, consumes load data and the freeze signal
    modport master (
        output ALU_ResIn,
        output Value_RmIn,
        output MEM_W_ENIn,
        output MEM_R_ENIn,
        input  readData,
        input  ready
    );

    // controller side
    modport slave (
        input  ALU_ResIn,
        input  Value_RmIn,
        input  MEM_W_ENIn,
        input  MEM_R_ENIn,
        output readData,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store over a 16-bit async SRAM in two fixed-length phases
module sram_controller #(
    parameter int N            = 32,
    parameter int SRAM_AW      = 18,
    parameter int SRAM_DW      = 16,
    parameter int PHASE_CYCLES = 2,
    parameter int BASE_ADDR    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]           cnt, cnt_nxt;
    logic                 req;
    logic                 phase_end;
    logic [N-1:0]         offset;
    logic [SRAM_AW-2:0]   word_idx;
    logic                 unused_bits;

    // Access context captured at request acceptance so a flush that drops the
    // request lines mid-access cannot corrupt the remaining phase.
    logic [SRAM_AW-2:0]   word_q;
    logic                 wr_q;
    logic [2*SRAM_DW-1:0] wdata_q;
    logic [SRAM_DW-1:0]   low_q;
    logic [N-1:0]         read_q;

    logic                 ready_c;
    logic                 dq_oe;
    logic [SRAM_DW-1:0]   dq_out;

    assign req       = bus.MEM_W_ENIn | bus.MEM_R_ENIn;
    assign phase_end = (cnt == 4'(PHASE_CYCLES - 1));

    // Byte address relative to the SRAM window; wraps below BASE_ADDR by design.
    assign offset      = bus.ALU_ResIn - N'(BASE_ADDR);
    assign word_idx    = offset[SRAM_AW:2];
    assign unused_bits = &{1'b0, offset[N-1:SRAM_AW+1], offset[1:0]};

    assign SRAM_DQ      = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign bus.ready    = ready_c;
    assign bus.readData = read_q;

    // State, phase counter and access context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            word_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            low_q   <= '0;
            read_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                word_q  <= word_idx;
                wr_q    <= bus.MEM_W_ENIn;
                wdata_q <= (2*SRAM_DW)'(bus.Value_RmIn);
            end
            if (state == LOW && phase_end && !wr_q) begin
                low_q <= SRAM_DQ;
            end
            if (state == HIGH && phase_end && !wr_q) begin
                read_q <= N'({SRAM_DQ, low_q});
            end
        end
    end

    // Next-state, counter and SRAM pin decode; DONE never looks at the request
    // lines because they still belong to the instruction that is completing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_c   = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            IDLE: begin
                ready_c = !req;
                if (req) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = !wr_q;
                dq_oe     = wr_q;
                dq_out    = wdata_q[SRAM_DW-1:0];
                if (phase_end) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = !wr_q;
                dq_oe     = wr_q;
                dq_out    = wdata_q[2*SRAM_DW-1:SRAM_DW];
                if (phase_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench for sram_controller with a small SRAM model
module tb_sram_controller;

    localparam int P = 2;

    logic        clk;
    logic        rst;
    logic        probe;
    logic        mem_init;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] mem [0:63];

    int checks;
    int failures;

    sram_controller_if #(.N(32)) bus ();

    sram_controller #(
        .N(32),
        .SRAM_AW(18),
        .SRAM_DW(16),
        .PHASE_CYCLES(P),
        .BASE_ADDR(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ(sram_dq),
        .SRAM_WE_N(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model drives the bus whenever the controller is not writing; probe
    // substitutes a marker so an illegal controller drive shows up as corruption.
    assign sram_dq = sram_we_n ? (probe ? 16'h5A5A : mem[sram_addr[5:0]]) : 16'hzzzz;

    // SRAM model storage with preset contents
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
            mem[2] <= 16'h1234;
            mem[3] <= 16'h5678;
            mem[7] <= 16'h0BAD;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full access; returns with the DONE cycle sampled and the request still held.
    task automatic access(input logic [31:0] addr, input logic [31:0] data,
                          input logic wen, input logic ren, input string tag);
        logic [31:0] a;
        logic [16:0] w;
        a = addr - 32'd1024;
        w = a[18:2];
        @(negedge clk);
        bus.ALU_ResIn  = addr;
        bus.Value_RmIn = data;
        bus.MEM_W_ENIn = wen;
        bus.MEM_R_ENIn = ren;
        #1;
        check($sformatf("%s_c0_ready", tag), 32'(bus.ready), 32'd0);
        for (int c = 1; c <= 2*P; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s_c%0d_ready", tag, c), 32'(bus.ready), 32'd0);
            check($sformatf("%s_c%0d_we_n", tag, c), 32'(sram_we_n), 32'(!wen));
            check($sformatf("%s_c%0d_addr", tag, c), 32'(sram_addr),
                  (c <= P) ? 32'({w, 1'b0}) : 32'({w, 1'b1}));
            if (wen) begin
                check($sformatf("%s_c%0d_dq", tag, c), 32'(sram_dq),
                      (c <= P) ? 32'(data[15:0]) : 32'(data[31:16]));
            end
        end
        @(negedge clk);
        #1;
        check($sformatf("%s_done_ready", tag), 32'(bus.ready), 32'd1);
        check($sformatf("%s_done_we_n", tag), 32'(sram_we_n), 32'd1);
        check($sformatf("%s_done_addr", tag), 32'(sram_addr), 32'd0);
    endtask

    task automatic idle_cycle(input string tag, input logic [31:0] exp_rd);
        @(negedge clk);
        bus.MEM_W_ENIn = 1'b0;
        bus.MEM_R_ENIn = 1'b0;
        probe = 1'b1;
        #1;
        check($sformatf("%s_idle_ready", tag), 32'(bus.ready), 32'd1);
        check($sformatf("%s_idle_rdata", tag), bus.readData, exp_rd);
        check($sformatf("%s_idle_dq_hiz", tag), 32'(sram_dq), 32'h5A5A);
        probe = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        mem_init       = 1'b1;
        probe          = 1'b0;
        bus.ALU_ResIn  = 32'd0;
        bus.Value_RmIn = 32'd0;
        bus.MEM_W_ENIn = 1'b0;
        bus.MEM_R_ENIn = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        mem_init = 1'b0;
        probe    = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_ready_%0d", i), 32'(bus.ready), 32'd1);
            check($sformatf("rst_rdata_%0d", i), bus.readData, 32'd0);
            check($sformatf("rst_we_n_%0d", i), 32'(sram_we_n), 32'd1);
            check($sformatf("rst_dq_hiz_%0d", i), 32'(sram_dq), 32'h5A5A);
            check($sformatf("rst_addr_%0d", i), 32'(sram_addr), 32'd0);
        end
        probe = 1'b0;

        access(32'd1024, 32'hDEADBEEF, 1'b1, 1'b0, "st1024");
        idle_cycle("st1024", 32'd0);
        check("st1024_mem0", 32'(mem[0]), 32'h0000BEEF);
        check("st1024_mem1", 32'(mem[1]), 32'h0000DEAD);

        access(32'd1024, 32'h0, 1'b0, 1'b1, "ld1024");
        check("ld1024_rdata_done", bus.readData, 32'hDEADBEEF);
        idle_cycle("ld1024", 32'hDEADBEEF);

        access(32'd1028, 32'h0, 1'b0, 1'b1, "ld1028");
        check("ld1028_rdata_done", bus.readData, 32'h56781234);
        idle_cycle("ld1028", 32'h56781234);

        access(32'd1032, 32'h0000FFFF, 1'b1, 1'b0, "b2b_st");
        access(32'd1032, 32'h0, 1'b0, 1'b1, "b2b_ld");
        check("b2b_rdata_done", bus.readData, 32'h0000FFFF);
        idle_cycle("b2b", 32'h0000FFFF);
        check("b2b_mem4", 32'(mem[4]), 32'h0000FFFF);
        check("b2b_mem5", 32'(mem[5]), 32'h00000000);

        access(32'd1024, 32'hCAFEF00D, 1'b1, 1'b1, "both");
        check("both_rdata_done", bus.readData, 32'h0000FFFF);
        idle_cycle("both", 32'h0000FFFF);
        check("both_mem0", 32'(mem[0]), 32'h0000F00D);
        check("both_mem1", 32'(mem[1]), 32'h0000CAFE);

        access(32'd1020, 32'h11112222, 1'b1, 1'b0, "wrap");
        idle_cycle("wrap", 32'h0000FFFF);
        check("wrap_mem62", 32'(mem[62]), 32'h00002222);
        check("wrap_mem63", 32'(mem[63]), 32'h00001111);

        @(negedge clk);
        bus.ALU_ResIn  = 32'd1036;
        bus.Value_RmIn = 32'hABCD9876;
        bus.MEM_W_ENIn = 1'b1;
        bus.MEM_R_ENIn = 1'b0;
        #1;
        check("rstmid_c0_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        #1;
        check("rstmid_c1_we_n", 32'(sram_we_n), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_c2_addr", 32'(sram_addr), 32'd6);
        @(negedge clk);
        rst            = 1'b0;
        bus.MEM_W_ENIn = 1'b0;
        probe          = 1'b1;
        #1;
        check("rstmid_ready", 32'(bus.ready), 32'd1);
        check("rstmid_we_n", 32'(sram_we_n), 32'd1);
        check("rstmid_dq_hiz", 32'(sram_dq), 32'h5A5A);
        check("rstmid_rdata", bus.readData, 32'd0);
        check("rstmid_addr", 32'(sram_addr), 32'd0);
        probe = 1'b0;
        check("rstmid_mem6", 32'(mem[6]), 32'h00009876);
        check("rstmid_mem7", 32'(mem[7]), 32'h00000BAD);

        @(negedge clk);
        #1;
        check("rstmid_after_ready", 32'(bus.ready), 32'd1);
        check("rstmid_after_we_n", 32'(sram_we_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
